// File: rtl/bp_update_arbiter_pkg.sv
// Shared types for the branch predictor update arbiter.
// Holds the update record and the default queue depth.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BP_UPD_FIFO_DEPTH
`define BP_UPD_FIFO_DEPTH 4
`endif

package bp_update_arbiter_pkg;

    localparam int XLEN           = `XLEN;
    localparam int UPD_FIFO_DEPTH = `BP_UPD_FIFO_DEPTH;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target_pc;
    } BP_UPDATE;

    function automatic logic [1:0] enq_count(input logic a, input logic b);
        return 2'(a) + 2'(b);
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Two-write / one-read circular buffer of predictor updates.
// Slot 1 is only written together with slot 0, keeping entries dense.
module bp_update_fifo
    import bp_update_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr0_en_i,
    input  BP_UPDATE      wr0_data_i,
    input  logic          wr1_en_i,
    input  BP_UPDATE      wr1_data_i,
    input  logic          rd_en_i,
    output BP_UPDATE      head_data_o,
    output logic [CW-1:0] count_o
);

    BP_UPDATE      mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    enq_cnt;

    // Pointer and count next-state; power-of-two depth makes wrap free.
    always_comb begin
        enq_cnt = enq_count(wr0_en_i, wr0_en_i & wr1_en_i);
        tail_p1 = tail_q + PW'(1);
        tail_d  = tail_q + PW'(enq_cnt);
        head_d  = head_q + PW'(rd_en_i);
        count_d = count_q + CW'(enq_cnt) - CW'(rd_en_i);
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero.
    always_ff @(posedge clock) begin
        if (wr0_en_i) begin
            mem_q[tail_q] <= wr0_data_i;
        end
        if (wr0_en_i && wr1_en_i) begin
            mem_q[tail_p1] <= wr1_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/bp_update_arbiter.sv
// Merges two branch-resolution pipes onto the predictor update port.
// Requests are queued in order; one update issues per cycle unless held.
module bp_update_arbiter
    import bp_update_arbiter_pkg::*;
#(
    parameter int  UPD_FIFO_DEPTH_P = UPD_FIFO_DEPTH,
    localparam int CW               = $clog2(UPD_FIFO_DEPTH_P) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [1:0][XLEN-1:0] req_pc,
    input  logic [1:0]           req_taken,
    input  logic [1:0][XLEN-1:0] req_target_pc,
    output logic                 req_ready,
    input  logic                 bp_hold,
    output logic                 upd_branch,
    output logic [XLEN-1:0]      upd_pc,
    output logic                 upd_taken,
    output logic [XLEN-1:0]      upd_target_pc,
    output logic [CW-1:0]        occupancy,
    output logic                 overflow_err
);

    BP_UPDATE      pipe0, pipe1;
    BP_UPDATE      slot0, slot1;
    BP_UPDATE      head;
    logic          wr0_en, wr1_en;
    logic          viol;
    logic          err_q, err_d;
    logic [CW-1:0] count;

    // Handshake, compaction of requests into write slots, and issue.
    always_comb begin
        pipe0     = '{pc: req_pc[0], taken: req_taken[0],
                      target_pc: req_target_pc[0]};
        pipe1     = '{pc: req_pc[1], taken: req_taken[1],
                      target_pc: req_target_pc[1]};
        // Ready ignores the same-cycle dequeue: always room for two.
        req_ready = count <= CW'(UPD_FIFO_DEPTH_P - 2);
        viol      = (|req_valid) & ~req_ready;
        wr0_en    = req_ready & (|req_valid);
        wr1_en    = req_ready & (&req_valid);
        slot0     = req_valid[0] ? pipe0 : pipe1;
        slot1     = pipe1;
        err_d     = err_q | viol;

        upd_branch    = (count != '0) & ~bp_hold;
        upd_pc        = '0;
        upd_taken     = 1'b0;
        upd_target_pc = '0;
        if (count != '0) begin
            upd_pc        = head.pc;
            upd_taken     = head.taken;
            upd_target_pc = head.target_pc;
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    bp_update_fifo #(
        .DEPTH (UPD_FIFO_DEPTH_P)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .wr0_en_i    (wr0_en),
        .wr0_data_i  (slot0),
        .wr1_en_i    (wr1_en),
        .wr1_data_i  (slot1),
        .rd_en_i     (upd_branch),
        .head_data_o (head),
        .count_o     (count)
    );

    assign occupancy    = count;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Scoreboard bench for the predictor update arbiter.
// Directed pushes queue expected updates; a monitor checks each issue.
module tb_bp_update_arbiter;
    import bp_update_arbiter_pkg::*;

    localparam int CW = $clog2(UPD_FIFO_DEPTH) + 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [1:0]           req_valid = '0;
    logic [1:0][XLEN-1:0] req_pc = '0;
    logic [1:0]           req_taken = '0;
    logic [1:0][XLEN-1:0] req_target_pc = '0;
    logic                 req_ready;
    logic                 bp_hold = 1'b0;
    logic                 upd_branch;
    logic [XLEN-1:0]      upd_pc;
    logic                 upd_taken;
    logic [XLEN-1:0]      upd_target_pc;
    logic [CW-1:0]        occupancy;
    logic                 overflow_err;

    BP_UPDATE sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bp_update_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_pc        (req_pc),
        .req_taken     (req_taken),
        .req_target_pc (req_target_pc),
        .req_ready     (req_ready),
        .bp_hold       (bp_hold),
        .upd_branch    (upd_branch),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target_pc (upd_target_pc),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] v,
                        input logic [31:0] pc0, input logic t0,
                        input logic [31:0] tg0,
                        input logic [31:0] pc1, input logic t1,
                        input logic [31:0] tg1);
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 64'(req_ready), 64'd1);
        req_valid        = v;
        req_pc[0]        = pc0;
        req_taken[0]     = t0;
        req_target_pc[0] = tg0;
        req_pc[1]        = pc1;
        req_taken[1]     = t1;
        req_target_pc[1] = tg1;
        if (v[0]) sb.push_back('{pc: pc0, taken: t0, target_pc: tg0});
        if (v[1]) sb.push_back('{pc: pc1, taken: t1, target_pc: tg1});
        step();
        req_valid = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || occupancy != '0) && n < 100) begin
            step();
            n++;
        end
        chk("drain", 64'(sb.size() == 0 && occupancy == '0), 64'd1);
    endtask

    // Monitor: every issued update must match the scoreboard head.
    always @(negedge clock) begin : monitor
        BP_UPDATE e;
        if (!reset) begin
            if (upd_branch) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL upd_unexpected: got pc %0h want none",
                             upd_pc);
                end else begin
                    e = sb.pop_front();
                    if (upd_pc !== e.pc || upd_taken !== e.taken ||
                        upd_target_pc !== e.target_pc) begin
                        n_bad++;
                        $display("FAIL upd_data: got %0h/%0b/%0h want %0h/%0b/%0h",
                                 upd_pc, upd_taken, upd_target_pc,
                                 e.pc, e.taken, e.target_pc);
                    end
                end
            end
            chk("no_gap", 64'(upd_branch),
                64'((occupancy != '0) && !bp_hold));
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_upd", 64'(upd_branch), 64'd0);
        chk("rst_err", 64'(overflow_err), 64'd0);
        reset = 1'b0;
        step();

        // Single request, one-cycle latency.
        push(2'b01, 32'h100, 1'b1, 32'h200, 32'h0, 1'b0, 32'h0);
        chk("t1_upd", 64'(upd_branch), 64'd1);
        chk("t1_occ1", 64'(occupancy), 64'd1);
        step();
        chk("t1_idle", 64'(upd_branch), 64'd0);
        chk("t1_occ0", 64'(occupancy), 64'd0);

        // Dual request, pipe 0 first.
        push(2'b11, 32'h10, 1'b0, 32'h14, 32'h20, 1'b1, 32'h80);
        chk("t2_occ2", 64'(occupancy), 64'd2);
        step();
        chk("t2_occ1", 64'(occupancy), 64'd1);
        step();
        chk("t2_occ0", 64'(occupancy), 64'd0);

        // Hold fills the queue, release drains in order.
        bp_hold = 1'b1;
        push(2'b11, 32'h1000, 1'b1, 32'h1100, 32'h1004, 1'b0, 32'h1104);
        push(2'b11, 32'h1008, 1'b0, 32'h1108, 32'h100c, 1'b1, 32'h110c);
        chk("t3_occ4", 64'(occupancy), 64'd4);
        chk("t3_ready0", 64'(req_ready), 64'd0);
        chk("t3_upd0", 64'(upd_branch), 64'd0);
        bp_hold = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            step();
            chk("t3_drain_occ", 64'(occupancy), 64'(i));
        end
        chk("t3_ready1", 64'(req_ready), 64'd1);

        // Wrap-around with alternating dual/single pushes.
        push(2'b11, 32'h04, 1'b1, 32'h104, 32'h08, 1'b0, 32'h108);
        push(2'b01, 32'h0c, 1'b1, 32'h10c, 32'h0, 1'b0, 32'h0);
        push(2'b11, 32'h10, 1'b0, 32'h110, 32'h14, 1'b1, 32'h114);
        push(2'b10, 32'h0, 1'b0, 32'h0, 32'h18, 1'b1, 32'h118);
        push(2'b11, 32'h1c, 1'b1, 32'h11c, 32'h20, 1'b0, 32'h120);
        push(2'b01, 32'h24, 1'b1, 32'h124, 32'h0, 1'b0, 32'h0);
        drain();

        // Violation: request while not ready is dropped.
        bp_hold = 1'b1;
        push(2'b11, 32'h300, 1'b1, 32'h310, 32'h304, 1'b0, 32'h314);
        push(2'b01, 32'h308, 1'b1, 32'h318, 32'h0, 1'b0, 32'h0);
        chk("t4_ready0", 64'(req_ready), 64'd0);
        req_valid        = 2'b10;
        req_pc[1]        = 32'h40;
        req_taken[1]     = 1'b1;
        req_target_pc[1] = 32'h44;
        step();
        req_valid = '0;
        chk("t4_err", 64'(overflow_err), 64'd1);
        chk("t4_occ3", 64'(occupancy), 64'd3);
        bp_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_sticky", 64'(overflow_err), 64'd1);
        end
        drain();

        // Asynchronous reset mid-cycle discards queued updates.
        bp_hold = 1'b1;
        push(2'b11, 32'h500, 1'b1, 32'h510, 32'h504, 1'b1, 32'h514);
        push(2'b01, 32'h508, 1'b0, 32'h518, 32'h0, 1'b0, 32'h0);
        bp_hold = 1'b0;
        #1;
        chk("t6_upd1", 64'(upd_branch), 64'd1);
        chk("t6_occ3", 64'(occupancy), 64'd3);
        reset = 1'b1;
        #1;
        chk("t6_occ0", 64'(occupancy), 64'd0);
        chk("t6_upd0", 64'(upd_branch), 64'd0);
        chk("t6_ready", 64'(req_ready), 64'd1);
        chk("t6_err0", 64'(overflow_err), 64'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_quiet", 64'(upd_branch), 64'd0);
        end
        push(2'b01, 32'h600, 1'b0, 32'h610, 32'h0, 1'b0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
